rst_sequencer: RTL

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/rst_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta;

  // Sample d through two flops; both clear to 0 under reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all channels after clock lock, then releases them
// one by one with a fixed stagger. Lock loss or a software request replays
// the sequence.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all channels asserted, waiting for synchronised lock
// HOLD      | all channels asserted, counting the hold period
// STAGGER   | releasing channels 1..N_CH-1, one per stagger period
// RUN       | all channels released; watching lock and software request
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            lock_i,
  input  logic            sw_req_i,
  output logic [N_CH-1:0] rst_o,
  output logic            done_o,
  output logic [1:0]      cause_o
);

  localparam int CW = $clog2(max_int(HOLD_CYC, STAGGER_CYC) + 1);
  localparam int IW = $clog2(N_CH + 1);

  // HOLD spans HOLD_CYC+1 edges: the counter runs 0..HOLD_CYC, and the
  // edge that sees HOLD_CYC releases channel 0.
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC);
  localparam logic [CW-1:0] STAG_END = CW'(STAGGER_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  logic            lock_s;
  seq_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_CH-1:0] rst_q, rst_d;
  logic            done_q, done_d;
  logic [1:0]      cause_q, cause_d;
  logic [N_CH-1:0] rel_mask;

  sync_2ff u_lock_sync (
    .clk  (clk),
    .srst (srst),
    .d    (lock_i),
    .q    (lock_s)
  );

  // Next-state and next-output decode; lock loss outranks software request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rst_d    = rst_q;
    done_d   = done_q;
    cause_d  = cause_q;
    rel_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (IW'(i) == idx_q) rel_mask[i] = 1'b1;
    end

    case (state_q)
      WAIT_LOCK: begin
        rst_d  = '1;
        done_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (lock_s) state_d = HOLD;
      end

      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
          done_d  = 1'b0;
          cause_d = CAUSE_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == HOLD_END) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (N_CH == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = STAGGER;
            idx_d   = IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STAGGER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
          done_d  = 1'b0;
          cause_d = CAUSE_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == STAG_END) begin
          rst_d = rst_q & ~rel_mask;
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
          done_d  = 1'b0;
          cause_d = CAUSE_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (sw_req_i) begin
          state_d = HOLD;
          rst_d   = '1;
          done_d  = 1'b0;
          cause_d = CAUSE_SW;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '1;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_o   = rst_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule
